// File: rtl/sin_voice_scheduler.sv
// -----------------------------------------------------------------------------
// sin_voice_scheduler
//   Shares one sine wavetable BRAM (1-cycle registered read) among VOICES
//   phase-accumulator voices. Each sample_tick starts a frame: one BRAM slot per
//   voice (ISSUE), one cycle to collect the last read (DRAIN), then the summed
//   signed samples appear on mix_out with a one-cycle mix_valid pulse.
//
// Ports
//   clk         system clock, shared with the BRAM
//   rst         synchronous, active-high reset
//   sample_tick 1-cycle pulse, starts one mix frame when idle
//   voice_en    per-voice enable; a disabled voice has its phase held at 0
//   phase_inc   per-voice phase increment, voice i at [i*PHASE_W +: PHASE_W]
//   bram_ce     BRAM read enable (combinational, only in ISSUE)
//   bram_addr   BRAM read address = top SAMPLE_ADDR_BITS of the slot's phase
//   bram_out    BRAM read data, valid the cycle after bram_ce
//   mix_out     signed sum of the enabled voices' samples of the last frame
//   mix_valid   1-cycle pulse when mix_out updates
//   busy        high while a frame is in progress
//   overrun     sticky flag: a sample_tick arrived while busy
// -----------------------------------------------------------------------------
module sin_voice_scheduler #(
  parameter int VOICES           = 4,
  parameter int DATA_W           = 16,
  parameter int SAMPLE_ADDR_BITS = 8,
  parameter int PHASE_W          = 24,
  localparam int IDX_W           = (VOICES > 1) ? $clog2(VOICES) : 1,
  localparam int MIX_W           = DATA_W + IDX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_tick,
  input  logic [VOICES-1:0]           voice_en,
  input  logic [VOICES*PHASE_W-1:0]   phase_inc,
  output logic                        bram_ce,
  output logic [SAMPLE_ADDR_BITS-1:0] bram_addr,
  input  logic [DATA_W-1:0]           bram_out,
  output logic [MIX_W-1:0]            mix_out,
  output logic                        mix_valid,
  output logic                        busy,
  output logic                        overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [PHASE_W-1:0] phase [VOICES];
  logic [MIX_W-1:0]   acc;
  logic               rd_vld;
  logic [MIX_W-1:0]   addend;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bram_ce   = 1'b0;
    bram_addr = phase[idx][PHASE_W-1 -: SAMPLE_ADDR_BITS];
    if (state == ISSUE) bram_ce = voice_en[idx];
  end

  // Read data from the previous slot, sign-extended; zero when that slot's
  // voice was disabled so stale BRAM data never leaks into the mix.
  assign addend = rd_vld ? {{(MIX_W-DATA_W){bram_out[DATA_W-1]}}, bram_out} : '0;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      rd_vld    <= 1'b0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      // NOTE: the phase array is a handful of flops, not a RAM, so it is reset
      // explicitly; voices must restart at phase 0 after reset.
      for (int k = 0; k < VOICES; k++) phase[k] <= '0;
    end else begin
      mix_valid <= 1'b0;
      rd_vld    <= bram_ce;

      // A disabled voice is parked at phase 0 every cycle; an enabled voice
      // advances only in its own ISSUE slot.
      for (int k = 0; k < VOICES; k++) begin
        if (!voice_en[k])
          phase[k] <= '0;
        else if (state == ISSUE && idx == IDX_W'(k))
          phase[k] <= phase[k] + phase_inc[k*PHASE_W +: PHASE_W];
      end

      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= ISSUE;
            idx   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (sample_tick) overrun <= 1'b1;
          acc <= acc + addend;
          if (idx == IDX_W'(VOICES-1)) begin
            state <= DRAIN;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          if (sample_tick) overrun <= 1'b1;
          // Last slot's read lands here; fold it in directly on the way out.
          mix_out   <= acc + addend;
          mix_valid <= 1'b1;
          state     <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sin_voice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sin_voice_scheduler
//   Directed bench for sin_voice_scheduler with a behavioural 1-cycle BRAM.
//   Table: addr 64 -> 0x7FFF, addr 192 -> 0x8001, otherwise {addr, 8'h5A}.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sin_voice_scheduler;

  localparam int VOICES = 4;
  localparam int DATA_W = 16;
  localparam int AW     = 8;
  localparam int PW     = 24;
  localparam int MIX_W  = 18;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sample_tick;
  logic [VOICES-1:0]    voice_en;
  logic [VOICES*PW-1:0] phase_inc;
  logic                 bram_ce;
  logic [AW-1:0]        bram_addr;
  logic [DATA_W-1:0]    bram_out;
  logic [MIX_W-1:0]     mix_out;
  logic                 mix_valid;
  logic                 busy;
  logic                 overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sin_voice_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .voice_en    (voice_en),
    .phase_inc   (phase_inc),
    .bram_ce     (bram_ce),
    .bram_addr   (bram_addr),
    .bram_out    (bram_out),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  function automatic logic [DATA_W-1:0] tbl(input logic [AW-1:0] a);
    if (a == 8'd64)       return 16'h7FFF;
    else if (a == 8'd192) return 16'h8001;
    else                  return {a, 8'h5A};
  endfunction

  function automatic logic [MIX_W-1:0] sext(input logic [DATA_W-1:0] d);
    return {{(MIX_W-DATA_W){d[DATA_W-1]}}, d};
  endfunction

  // Behavioural BRAM; returns junk when not enabled so unqualified reads show up.
  always @(posedge clk) bram_out <= bram_ce ? tbl(bram_addr) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_inc(input int k, input logic [PW-1:0] v);
    phase_inc[k*PW +: PW] = v;
  endtask

  // Pulse sample_tick and wait (bounded) for mix_valid; latency must be 6 samples.
  task automatic run_frame(input string tag, input logic [MIX_W-1:0] exp);
    int n;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    n = 1;
    while (!mix_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, 6);
    check(tag, mix_out, exp);
    @(negedge clk);
  endtask

  initial begin
    int quiet;
    rst         = 1'b1;
    sample_tick = 1'b0;
    voice_en    = '0;
    phase_inc   = '0;

    // 1: reset
    repeat (3) @(negedge clk);
    check("rst_mix_out", mix_out, 0);
    check("rst_mix_valid", mix_valid, 0);
    check("rst_bram_ce", bram_ce, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    // 2: voice0 only, address steps by one per frame and wraps after 256
    voice_en = 4'b0001;
    set_inc(0, 24'h010000);
    for (int f = 0; f < 260; f++) begin
      logic [AW-1:0] a;
      a = f[AW-1:0];
      run_frame($sformatf("walk%0d", f), sext(tbl(a)));
    end

    // 3: all four voices at addr 64 -> 4*0x7FFF
    voice_en = 4'b0000;
    @(negedge clk);
    voice_en = 4'b1111;
    for (int k = 0; k < VOICES; k++) set_inc(k, 24'h400000);
    run_frame("setup64", 18'h00168);
    phase_inc = '0;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      check($sformatf("t3_ce_%0d", j), bram_ce, (j <= 4) ? 1 : 0);
      check($sformatf("t3_valid_%0d", j), mix_valid, (j == 6) ? 1 : 0);
      check($sformatf("t3_busy_%0d", j), busy, (j <= 5) ? 1 : 0);
      if (j == 6) check("t3_mix", mix_out, 18'h1FFFC);
      if (j < 7) @(negedge clk);
    end

    // 4: negative sample sign-extends
    voice_en = 4'b0001;
    set_inc(0, 24'h800000);
    run_frame("t4_at64", 18'h07FFF);
    set_inc(0, 24'h000000);
    run_frame("t4_at192", 18'h38001);

    // 5: tick inside a frame is ignored and sets sticky overrun
    voice_en = 4'b1111;
    check("t5_overrun_before", overrun, 0);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      if (j == 2) sample_tick = 1'b1;
      if (j == 3) sample_tick = 1'b0;
      check($sformatf("t5_valid_%0d", j), mix_valid, (j == 6) ? 1 : 0);
      check($sformatf("t5_busy_%0d", j), busy, (j <= 5) ? 1 : 0);
      if (j >= 3) check($sformatf("t5_overrun_%0d", j), overrun, 1);
      if (j == 6) check("t5_mix", mix_out, 18'h3810F);
      if (j < 7) @(negedge clk);
    end
    run_frame("t5_next", 18'h3810F);
    check("t5_overrun_sticky", overrun, 1);

    // 6: dropping voice_en[2] for one cycle resets its phase
    set_inc(2, 24'h100000);
    run_frame("t6_adv", 18'h3810F);
    phase_inc = '0;
    voice_en = 4'b1011;
    @(negedge clk);
    voice_en = 4'b1111;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      if (j == 3) begin
        check("t6_reen_addr", bram_addr, 0);
        check("t6_reen_ce", bram_ce, 1);
      end
      if (j == 6) check("t6_reen_mix", mix_out, 18'h3810F);
      if (j < 6) @(negedge clk);
    end
    @(negedge clk);
    voice_en = 4'b1011;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      if (j == 3) check("t6_off_ce", bram_ce, 0);
      if (j == 6) begin
        check("t6_off_valid", mix_valid, 1);
        check("t6_off_mix", mix_out, 18'h380B5);
      end
      if (j < 6) @(negedge clk);
    end
    @(negedge clk);

    // 7: reset during ISSUE idx=2 aborts the frame
    voice_en = 4'b1111;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t7_busy", busy, 0);
    check("t7_mix_out", mix_out, 0);
    check("t7_overrun", overrun, 0);
    rst = 1'b0;
    quiet = 1;
    for (int j = 0; j < 8; j++) begin
      if (mix_valid) quiet = 0;
      @(negedge clk);
    end
    check("t7_no_valid", quiet, 1);
    run_frame("t7_after", 18'h00168);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
